// File: rtl/ddr3_arb_pkg.sv
// Shared types and sizes for the ddr3 system-port arbiter.
package ddr3_arb_pkg;

  localparam int DDR_AW = 29;
  localparam int DDR_DW = 256;
  localparam int DDR_MW = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LO,
    WAIT_HI,
    DONE
  } state_t;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first pending request at or after ptr, wrapping.
module rr_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          valid
);

  logic [PW-1:0] cand [N];

  // Search order starting at ptr, wrapping modulo N.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cand[i] = PW'((int'(ptr) + i) % N);
    end
  end

  // Take the first candidate with a pending request.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid && req[cand[i]]) begin
        valid            = 1'b1;
        grant_idx        = cand[i];
        grant[cand[i]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Shares the single ddr3 controller system port between NREQ requesters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | controller ready and a request pending -> latch winner
// ISSUE   | one-cycle srd/swr strobe with latched command
// WAIT_LO | wait for the controller to go busy (srdy low)
// WAIT_HI | wait for the controller to finish (srdy high)
// DONE    | req_done pulse to the granted requester, advance ptr
module ddr3_port_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_rd,
  input  logic [NREQ-1:0]        req_wr,
  input  logic [NREQ*DDR_AW-1:0] req_a,
  input  logic [NREQ*DDR_DW-1:0] req_wdat,
  input  logic [NREQ*DDR_MW-1:0] req_msk,
  output logic [NREQ-1:0]        req_done,
  output logic                   req_err,
  output logic [DDR_DW-1:0]      rdat,
  output logic                   srd,
  output logic                   swr,
  output logic [DDR_AW-1:0]      sa,
  output logic [DDR_DW-1:0]      swdat,
  output logic [DDR_MW-1:0]      smsk,
  input  logic [DDR_DW-1:0]      srdat,
  input  logic                   srdy,
  output logic                   err_sticky
);

  localparam int PW = clog2(NREQ);
  localparam int WW = clog2(TIMEOUT);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr, g_idx, arb_idx;
  logic [NREQ-1:0]   g_oh, arb_grant, req_any;
  logic              arb_valid, is_wr, timed_out;
  logic              latch_en, cap_rd, to_hit;
  logic [WW-1:0]     wd;
  logic [DDR_AW-1:0] sel_a;
  logic [DDR_DW-1:0] sel_wdat;
  logic [DDR_MW-1:0] sel_msk;
  logic              sel_wr;

  assign req_any = req_rd | req_wr;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
    .req       (req_any),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  // Select the winning requester's command; write wins over a simultaneous read.
  always_comb begin
    sel_a    = '0;
    sel_wdat = '0;
    sel_msk  = '0;
    sel_wr   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == PW'(i)) begin
        sel_a    = req_a[i*DDR_AW +: DDR_AW];
        sel_wdat = req_wdat[i*DDR_DW +: DDR_DW];
        sel_msk  = req_msk[i*DDR_MW +: DDR_MW];
        sel_wr   = req_wr[i];
      end
    end
  end

  // Next-state logic; in WAIT_HI a real completion beats the watchdog.
  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    cap_rd    = 1'b0;
    to_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (srdy && arb_valid) begin
          latch_en  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = WAIT_LO;
      WAIT_LO: begin
        if (wd == WD_LAST) begin
          to_hit    = 1'b1;
          state_nxt = DONE;
        end else if (!srdy) begin
          state_nxt = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (srdy) begin
          cap_rd    = !is_wr;
          state_nxt = DONE;
        end else if (wd == WD_LAST) begin
          to_hit    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign srd      = (state == ISSUE) && !is_wr;
  assign swr      = (state == ISSUE) && is_wr;
  assign req_done = (state == DONE) ? g_oh : '0;
  assign req_err  = (state == DONE) && timed_out;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Latched command, held on the controller port from ISSUE through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_oh  <= '0;
      g_idx <= '0;
      is_wr <= 1'b0;
      sa    <= '0;
      swdat <= '0;
      smsk  <= '0;
    end else if (latch_en) begin
      g_oh  <= arb_grant;
      g_idx <= arb_idx;
      is_wr <= sel_wr;
      sa    <= sel_a;
      swdat <= sel_wdat;
      smsk  <= sel_msk;
    end
  end

  // Watchdog: cleared when a command is launched, counts while waiting on srdy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd        <= '0;
      timed_out <= 1'b0;
    end else begin
      if (latch_en) begin
        wd        <= '0;
        timed_out <= 1'b0;
      end else if (state == WAIT_LO || state == WAIT_HI) begin
        wd <= wd + 1'b1;
      end
      if (to_hit) timed_out <= 1'b1;
    end
  end

  // Error flag survives everything but reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         err_sticky <= 1'b0;
    else if (to_hit) err_sticky <= 1'b1;
  end

  // Read data is taken as srdy rises so it is already valid during DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rdat <= '0;
    else if (cap_rd) rdat <= srdat;
  end

  // Round-robin pointer moves past the requester just served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (state == DONE) begin
      ptr <= (g_idx == PW'(NREQ - 1)) ? '0 : g_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Randomized bench for ddr3_port_arbiter with a behavioural controller and reference model.
module tb_ddr3_port_arbiter;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_rd, req_wr;
  logic [NREQ*29-1:0]  req_a;
  logic [NREQ*256-1:0] req_wdat;
  logic [NREQ*32-1:0]  req_msk;
  logic [NREQ-1:0]     req_done;
  logic                req_err;
  logic [255:0]        rdat;
  logic                srd, swr;
  logic [28:0]         sa;
  logic [255:0]        swdat;
  logic [31:0]         smsk;
  logic [255:0]        srdat;
  logic                srdy;
  logic                err_sticky;

  always #5 clk = ~clk;

  ddr3_port_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_rd     (req_rd),
    .req_wr     (req_wr),
    .req_a      (req_a),
    .req_wdat   (req_wdat),
    .req_msk    (req_msk),
    .req_done   (req_done),
    .req_err    (req_err),
    .rdat       (rdat),
    .srd        (srd),
    .swr        (swr),
    .sa         (sa),
    .swdat      (swdat),
    .smsk       (smsk),
    .srdat      (srdat),
    .srdy       (srdy),
    .err_sticky (err_sticky)
  );

  int           n_chk = 0;
  int           n_err = 0;
  int           viol  = 0;
  logic         swr_q = 1'b0;
  int           m_ptr = 0;
  logic [255:0] m_rdat = '0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobe rules on the controller port: never both, never swr on consecutive cycles.
  always @(negedge clk) begin
    if (!rst) begin
      if ((srd && swr) || (swr && swr_q)) viol <= viol + 1;
      swr_q <= swr;
    end else begin
      swr_q <= 1'b0;
    end
  end

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // kind: 0 none, 1 read, 2 write, 3 read+write
  task automatic set_req(input int i, input int kind);
    req_rd[i] = kind[0];
    req_wr[i] = kind[1];
    req_a[i*29 +: 29]     = 29'($urandom);
    req_wdat[i*256 +: 256] = rand256();
    req_msk[i*32 +: 32]   = $urandom;
  endtask

  // Expected winner: first pending index at or after the model pointer, wrapping.
  function automatic int pick();
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (req_rd[idx] || req_wr[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic wait_strobe(output bit seen);
    int n;
    n = 0;
    while (!(srd || swr) && n < 20) begin
      @(negedge clk);
      n++;
    end
    seen = srd || swr;
    chk("strobe_seen", 256'(seen), 256'(1));
  endtask

  // One transaction: controller keeps srdy high for lat cycles, busy for busy cycles.
  task automatic run_txn(input int lat, input int busy, input logic [255:0] val, output int w);
    bit           exp_wr, early, seen;
    logic [28:0]  ea;
    logic [255:0] ed;
    logic [31:0]  em;
    w = pick();
    if (w < 0) return;
    exp_wr = req_wr[w];
    ea = req_a[w*29 +: 29];
    ed = req_wdat[w*256 +: 256];
    em = req_msk[w*32 +: 32];
    wait_strobe(seen);
    if (!seen) return;
    chk("strobe_kind", 256'({srd, swr}), 256'(exp_wr ? 2'b01 : 2'b10));
    chk("sa", 256'(sa), 256'(ea));
    if (exp_wr) begin
      chk("swdat", swdat, ed);
      chk("smsk", 256'(smsk), 256'(em));
    end
    if ($urandom_range(0, 3) == 0) begin
      req_rd[w] = 1'b0;
      req_wr[w] = 1'b0;
    end
    early = 1'b0;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      early |= (srd | swr | (|req_done));
    end
    for (int k = 0; k < busy; k++) begin
      @(negedge clk);
      srdy = 1'b0;
      srdat = rand256();
      early |= (srd | swr | (|req_done));
    end
    @(negedge clk);
    srdy  = 1'b1;
    srdat = val;
    early |= (srd | swr | (|req_done));
    @(negedge clk);
    chk("no_early", 256'(early), 256'(0));
    chk("done_vec", 256'(req_done), 256'(1 << w));
    chk("req_err", 256'(req_err), 256'(0));
    if (!exp_wr) m_rdat = val;
    chk("rdat", rdat, m_rdat);
    chk("sa_hold", 256'(sa), 256'(ea));
    m_ptr = (w + 1) % NREQ;
    req_rd[w] = 1'b0;
    req_wr[w] = 1'b0;
  endtask

  // Controller never completes: the watchdog must end the transaction.
  task automatic run_timeout();
    int w, n;
    bit seen;
    w = pick();
    if (w < 0) return;
    wait_strobe(seen);
    if (!seen) return;
    chk("to_kind", 256'({srd, swr}), 256'(2'b10));
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) srdy = 1'b0;
      srdat = rand256();
    end while (!(|req_done) && n < 40);
    chk("to_cycles", 256'(n), 256'(TIMEOUT + 1));
    chk("to_done_vec", 256'(req_done), 256'(1 << w));
    chk("to_err", 256'(req_err), 256'(1));
    chk("to_sticky", 256'(err_sticky), 256'(1));
    chk("to_rdat", rdat, m_rdat);
    srdy = 1'b1;
    m_ptr = (w + 1) % NREQ;
    req_rd[w] = 1'b0;
    req_wr[w] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "bench timeout");
  end

  initial begin
    int  w;
    bit  seen, early;
    rst      = 1'b1;
    srdy     = 1'b0;
    srdat    = '0;
    req_rd   = '0;
    req_wr   = '0;
    req_a    = '0;
    req_wdat = '0;
    req_msk  = '0;
    repeat (3) @(negedge clk);
    chk("rst_done", 256'(req_done), 256'(0));
    chk("rst_strobe", 256'({srd, swr}), 256'(0));
    chk("rst_sa", 256'(sa), 256'(0));
    chk("rst_rdat", rdat, 256'(0));
    chk("rst_sticky", 256'(err_sticky), 256'(0));
    rst = 1'b0;

    // Controller still initialising: a pending request must wait.
    set_req(0, 1);
    req_a[28:0] = 29'h0000123;
    early = 1'b0;
    repeat (6) begin
      @(negedge clk);
      early |= (srd | swr);
    end
    chk("idle_busy", 256'(early), 256'(0));
    srdy = 1'b1;
    run_txn(0, 10, {32{8'hA5}}, w);

    // Fairness: both hold writes continuously.
    set_req(0, 2);
    set_req(1, 2);
    for (int t = 0; t < 8; t++) begin
      run_txn($urandom_range(0, 3), $urandom_range(1, 6), rand256(), w);
      set_req(w, 2);
    end
    req_wr = '0;

    // Read and write together from requester 1 is a write.
    set_req(1, 3);
    run_txn(1, 4, rand256(), w);

    // Controller keeps srdy high for a while after the strobe.
    set_req(0, 1);
    run_txn(3, 4, rand256(), w);

    set_req(1, 1);
    run_timeout();

    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(req_rd[i] || req_wr[i]) && ($urandom_range(0, 1) == 1))
          set_req(i, int'($urandom_range(1, 3)));
      end
      if (pick() < 0) set_req(int'($urandom_range(0, NREQ - 1)), int'($urandom_range(1, 3)));
      run_txn(int'($urandom_range(0, 3)), int'($urandom_range(1, 10)), rand256(), w);
    end

    // Reset in the middle of a transaction (WAIT_HI).
    req_rd = '0;
    req_wr = '0;
    set_req(1, 1);
    wait_strobe(seen);
    @(negedge clk);
    srdy = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_done", 256'(req_done), 256'(0));
    chk("mid_rst_strobe", 256'({srd, swr}), 256'(0));
    chk("mid_rst_sa", 256'(sa), 256'(0));
    chk("mid_rst_rdat", rdat, 256'(0));
    chk("mid_rst_sticky", 256'(err_sticky), 256'(0));
    m_ptr  = 0;
    m_rdat = '0;
    @(negedge clk);
    rst = 1'b0;
    early = 1'b0;
    repeat (8) begin
      @(negedge clk);
      early |= (srd | swr);
    end
    chk("post_rst_hold", 256'(early), 256'(0));
    srdy = 1'b1;
    run_txn(2, 3, rand256(), w);
    chk("sticky_after_rst", 256'(err_sticky), 256'(0));

    @(negedge clk);
    chk("proto", 256'(viol), 256'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
